// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the RISC-CPU blocks (controller, memory, IR, PC).
// Holds the datapath widths, the fixed ISA opcode encoding, the names of
// the eight instruction-cycle phases and a helper that classifies opcodes
// which read an operand from memory and write the accumulator.
package cpu_pkg;

    localparam int OPC_W   = 3;
    localparam int PHASE_W = 3;

    localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPC_W-1:0] OP_AND = 3'd3;
    localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
    localparam logic [OPC_W-1:0] OP_STO = 3'd6;
    localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

    localparam logic [PHASE_W-1:0] PH_INST_ADDR  = 3'd0;
    localparam logic [PHASE_W-1:0] PH_INST_FETCH = 3'd1;
    localparam logic [PHASE_W-1:0] PH_INST_LOAD  = 3'd2;
    localparam logic [PHASE_W-1:0] PH_IDLE       = 3'd3;
    localparam logic [PHASE_W-1:0] PH_OP_ADDR    = 3'd4;
    localparam logic [PHASE_W-1:0] PH_OP_FETCH   = 3'd5;
    localparam logic [PHASE_W-1:0] PH_ALU_OP     = 3'd6;
    localparam logic [PHASE_W-1:0] PH_STORE      = 3'd7;

    // Opcodes that fetch a memory operand and load the accumulator.
    function automatic logic is_aluop(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// cpu_phase_counter
// Wrapping phase counter for the instruction cycle.
// Ports:
//   clk    - system clock, posedge triggered
//   rst_n  - asynchronous active-low clear to phase 0
//   hold   - when 1 the count keeps its value
//   count  - current phase, wraps from the last phase back to 0
module cpu_phase_counter
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    output logic [PHASE_W-1:0] count
);

    // The counter is exactly PHASE_W bits wide, so the wrap 7->0 is the
    // natural modulo overflow of the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!hold) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller
// Sequencer for the RISC-CPU. Steps a fixed 8-phase instruction cycle and
// decodes the registered phase, the IR opcode and the ALU zero flag into the
// control strobes for memory, IR, PC, accumulator and data-bus driver.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   opcode     - IR opcode field (used in phases 4-7)
//   zero       - accumulator-is-zero flag (used in phase 6)
//   sel        - memory address source: 1 = PC, 0 = IR operand
//   mem_rd     - memory read enable
//   mem_wr     - memory write enable
//   ld_ir      - load instruction register
//   inc_pc     - increment program counter
//   ld_pc      - load program counter from IR operand
//   ld_ac      - load accumulator from ALU
//   data_e     - drive accumulator onto the data bus
//   halt       - CPU halted (or about to halt in phase 4)
//   phase      - current phase, for trace
module cpu_controller
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    output logic               sel,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               data_e,
    output logic               halt,
    output logic [PHASE_W-1:0] phase
);

    logic halted;
    logic halt_now;
    logic aluop;

    // A HLT seen in OP_ADDR freezes the machine on the very edge that would
    // otherwise leave phase 4, so the counter must already hold on that edge.
    assign halt_now = (phase == PH_OP_ADDR) && (opcode == OP_HLT) && !halted;
    assign aluop    = is_aluop(opcode);

    cpu_phase_counter u_phase_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (halted | halt_now),
        .count (phase)
    );

    // Sticky halt flag; only reset leaves the halted state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (halt_now) begin
            halted <= 1'b1;
        end
    end

    // Strobe decode. The write-side strobes (mem_wr, data_e) only appear for
    // STO, which never asserts mem_rd in phases 5-7, keeping the bus safe.
    always_comb begin
        sel    = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;

        case (phase)
            PH_INST_ADDR: begin
                sel = 1'b1;
            end
            PH_INST_FETCH: begin
                sel    = 1'b1;
                mem_rd = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel    = 1'b1;
                mem_rd = 1'b1;
                ld_ir  = 1'b1;
            end
            PH_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == OP_HLT);
            end
            PH_OP_FETCH: begin
                mem_rd = aluop;
            end
            PH_ALU_OP: begin
                mem_rd = aluop;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
                mem_rd = aluop;
                inc_pc = (opcode == OP_JMP);
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
                ld_ac  = aluop;
                mem_wr = (opcode == OP_STO);
            end
            default: begin
                sel = 1'b0;
            end
        endcase

        // Once halted the phase sits at 4, whose normal decode would keep
        // bumping the PC; suppress everything except halt.
        if (halted) begin
            sel    = 1'b0;
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            data_e = 1'b0;
            halt   = 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
// Bench for cpu_controller: directed instruction cases with hand-written
// per-phase strobe patterns, a halt/async-reset scenario, and a randomized
// run compared every cycle against a behavioural model of the sequencer.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic               clk    = 1'b0;
    logic               rst_n  = 1'b0;
    logic [OPC_W-1:0]   opcode = OP_LDA;
    logic               zero   = 1'b0;
    logic               sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
    logic [PHASE_W-1:0] phase;

    int checks = 0;
    int passes = 0;
    bit check_en = 1'b0;

    // Behavioural model state: which step of the 8-step cycle, and frozen or not.
    int m_phase = 0;
    bit m_halted = 1'b0;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Model: one step per clock modulo 8, frozen after HLT in step 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_halted <= 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 4 && opcode == OP_HLT) m_halted <= 1'b1;
            else m_phase <= (m_phase + 1) % 8;
        end
    end

    // Expected strobes, order {sel,mem_rd,mem_wr,ld_ir,inc_pc,ld_pc,ld_ac,data_e,halt}.
    function automatic logic [8:0] model_strobes(input int ph, input bit hlt,
                                                 input logic [OPC_W-1:0] op, input logic z);
        bit alu, e_sel, e_rd, e_wr, e_ir, e_inc, e_ldpc, e_ldac, e_de, e_halt;
        if (hlt) return 9'b0_0000_0001;
        alu    = (op >= 3'd2) && (op <= 3'd5);
        e_sel  = (ph <= 3);
        e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        e_ir   = (ph == 2) || (ph == 3);
        e_inc  = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
        e_ldpc = (ph >= 6) && (op == 3'd7);
        e_de   = (ph >= 6) && (op == 3'd6);
        e_ldac = (ph == 7) && alu;
        e_wr   = (ph == 7) && (op == 3'd6);
        e_halt = (ph == 4) && (op == 3'd0);
        return {e_sel, e_rd, e_wr, e_ir, e_inc, e_ldpc, e_ldac, e_de, e_halt};
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cycle.strobes",
                        16'({sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}),
                        16'(model_strobes(m_phase, m_halted, opcode, zero)));
            checkOutput("cycle.phase", 16'(phase), 16'(m_phase));
        end
    end

    // Runs one instruction from phase 0 and collects each strobe as an
    // 8-bit vector whose bit i is the strobe value during phase i.
    task automatic applyStimulus(input logic [OPC_W-1:0] op, input logic [7:0] zpat,
                                 output logic [7:0] v_sel, output logic [7:0] v_rd,
                                 output logic [7:0] v_wr, output logic [7:0] v_ir,
                                 output logic [7:0] v_inc, output logic [7:0] v_ldpc,
                                 output logic [7:0] v_ldac, output logic [7:0] v_de);
        int n = 0;
        while (phase !== 3'd0 && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("align", 16'(phase), 16'd0);
        opcode = op;
        for (int i = 0; i < 8; i++) begin
            zero = zpat[i];
            @(negedge clk);
            v_sel[i] = sel;     v_rd[i] = mem_rd;  v_wr[i] = mem_wr;  v_ir[i] = ld_ir;
            v_inc[i] = inc_pc;  v_ldpc[i] = ld_pc; v_ldac[i] = ld_ac; v_de[i] = data_e;
            @(posedge clk); #1;
        end
    endtask

    task automatic runCase(input string name, input logic [OPC_W-1:0] op, input logic [7:0] zpat,
                           input logic [7:0] x_rd, input logic [7:0] x_wr, input logic [7:0] x_inc,
                           input logic [7:0] x_ldpc, input logic [7:0] x_ldac, input logic [7:0] x_de);
        logic [7:0] v_sel, v_rd, v_wr, v_ir, v_inc, v_ldpc, v_ldac, v_de;
        applyStimulus(op, zpat, v_sel, v_rd, v_wr, v_ir, v_inc, v_ldpc, v_ldac, v_de);
        checkOutput({name, ".sel"},    16'(v_sel),  16'h0F);
        checkOutput({name, ".ld_ir"},  16'(v_ir),   16'h0C);
        checkOutput({name, ".mem_rd"}, 16'(v_rd),   16'(x_rd));
        checkOutput({name, ".mem_wr"}, 16'(v_wr),   16'(x_wr));
        checkOutput({name, ".inc_pc"}, 16'(v_inc),  16'(x_inc));
        checkOutput({name, ".ld_pc"},  16'(v_ldpc), 16'(x_ldpc));
        checkOutput({name, ".ld_ac"},  16'(v_ldac), 16'(x_ldac));
        checkOutput({name, ".data_e"}, 16'(v_de),   16'(x_de));
    endtask

    initial begin
        int bad;
        int hcnt;

        // Reset held for three clocks, released between edges.
        repeat (3) @(posedge clk);
        check_en = 1'b1;
        #2 rst_n = 1'b1;
        checkOutput("reset.phase", 16'(phase), 16'd0);
        checkOutput("reset.strobes",
                    16'({sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}), 16'h100);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            checkOutput("reset.seq", 16'(phase), 16'(i % 8));
        end

        //         name        op      zpat   rd     wr     inc    ldpc   ldac   de
        runCase("lda",       OP_LDA, 8'h00, 8'hEE, 8'h00, 8'h10, 8'h00, 8'h80, 8'h00);
        runCase("sto",       OP_STO, 8'h00, 8'h0E, 8'h80, 8'h10, 8'h00, 8'h00, 8'hC0);
        runCase("skz_z1",    OP_SKZ, 8'h40, 8'h0E, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00);
        runCase("skz_z0",    OP_SKZ, 8'hBF, 8'h0E, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00);
        runCase("skz_ph5",   OP_SKZ, 8'h20, 8'h0E, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00);
        runCase("jmp",       OP_JMP, 8'h00, 8'h0E, 8'h00, 8'h90, 8'hC0, 8'h00, 8'h00);
        runCase("add",       OP_ADD, 8'hFF, 8'hEE, 8'h00, 8'h10, 8'h00, 8'h80, 8'h00);

        // HLT: reach phase 4, then the machine must freeze there.
        zero = 1'b0;
        opcode = OP_HLT;
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("hlt.phase4", 16'(phase), 16'd4);
        checkOutput("hlt.decode4",
                    16'({sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}), 16'h011);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            zero = 1'($urandom_range(0, 1));
            if (phase !== 3'd4) bad++;
            if ({sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt} !== 9'h001) bad++;
        end
        checkOutput("hlt.frozen", 16'(bad), 16'd0);

        // Asynchronous reset in the middle of a halted cycle.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("hlt.rst_phase", 16'(phase), 16'd0);
        checkOutput("hlt.rst_strobes",
                    16'({sel, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt}), 16'h100);
        opcode = OP_LDA;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("hlt.resume", 16'(phase), 16'd1);

        // Randomized run; the per-cycle compare process does the checking.
        hcnt = 0;
        repeat (800) begin
            @(posedge clk); #2;
            if (m_halted) begin
                hcnt++;
                if (hcnt > 6) begin
                    rst_n = 1'b0;
                    opcode = OP_XOR;
                    #1 rst_n = 1'b1;
                    hcnt = 0;
                end
            end else if (m_phase <= 2 && $urandom_range(0, 3) == 0) begin
                opcode = ($urandom_range(0, 11) == 0) ? OP_HLT : 3'($urandom_range(1, 7));
            end
            zero = 1'($urandom_range(0, 1));
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
